// File: rtl/cell_census.sv
// Sequential live-cell census: row-serial popcount, double-dabble BCD, seven-segment output.
// Optional leading-zero blanking when CENSUS_BLANK_EN is defined.
module cell_census #(
   parameter  int WIDTH  = 20,
   parameter  int HEIGHT = 15,
   parameter  int DIGITS = 4,
   localparam int CW     = $clog2(WIDTH*HEIGHT+1)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [HEIGHT-1:0][WIDTH-1:0]   grid,
   output logic                           busy,
   output logic                           done,
   output logic [CW-1:0]                  count,
   output logic                           overflow,
   output logic [8*DIGITS-1:0]            display_data
);

   localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int BW   = (CW > 1) ? $clog2(CW) : 1;
   localparam int BCDW = 4*DIGITS;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

   localparam logic [63:0] LIMIT = pow10(DIGITS);

   function automatic logic [7:0] seg(input logic [3:0] d);
      case (d)
         4'd0: seg = 8'h3F;
         4'd1: seg = 8'h06;
         4'd2: seg = 8'h5B;
         4'd3: seg = 8'h4F;
         4'd4: seg = 8'h66;
         4'd5: seg = 8'h6D;
         4'd6: seg = 8'h7D;
         4'd7: seg = 8'h07;
         4'd8: seg = 8'h7F;
         4'd9: seg = 8'h6F;
         default: seg = 8'h00;
      endcase
   endfunction

   function automatic logic [8*DIGITS-1:0] render(input logic [BCDW-1:0] b);
      logic [8*DIGITS-1:0] r;
`ifdef CENSUS_BLANK_EN
      logic lead;
      r    = '0;
      lead = 1'b1;
      // Scan from the top digit; zeros stay blank until the first nonzero digit.
      for (int i = DIGITS-1; i >= 0; i--) begin
         if (b[4*i +: 4] != 4'd0) lead = 1'b0;
         r[8*i +: 8] = (lead && i != 0) ? 8'h00 : seg(b[4*i +: 4]);
      end
`else
      r = '0;
      for (int i = 0; i < DIGITS; i++) r[8*i +: 8] = seg(b[4*i +: 4]);
`endif
      return r;
   endfunction

   function automatic logic [CW-1:0] popcnt(input logic [WIDTH-1:0] row_bits);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < WIDTH; i++) c = c + CW'(row_bits[i]);
      return c;
   endfunction

   localparam logic [8*DIGITS-1:0] RST_DISP = render('0);

   typedef enum logic [1:0] {IDLE, SCAN, CONVERT, UPDATE} state_t;

   state_t                       state, next;
   logic [HEIGHT-1:0][WIDTH-1:0] snap;
   logic [CW-1:0]                acc, acc_nxt, shreg;
   logic [BCDW-1:0]              bcd, adj;
   logic [RW-1:0]                row;
   logic [BW-1:0]                bit_cnt;
   logic                         last_row, last_bit;

   assign acc_nxt  = acc + popcnt(snap[row]);
   assign last_row = (row == RW'(HEIGHT-1));
   assign last_bit = (bit_cnt == BW'(CW-1));
   assign busy     = (state != IDLE);

   always_comb begin
      adj = bcd;
      for (int i = 0; i < DIGITS; i++)
         if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= next;

   always_comb begin
      next = state;
      case (state)
         IDLE:    if (start)    next = SCAN;
         SCAN:    if (last_row) next = CONVERT;
         CONVERT: if (last_bit) next = UPDATE;
         UPDATE:                next = IDLE;
         default:               next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap         <= '0;
         acc          <= '0;
         shreg        <= '0;
         bcd          <= '0;
         row          <= '0;
         bit_cnt      <= '0;
         done         <= 1'b0;
         count        <= '0;
         overflow     <= 1'b0;
         display_data <= RST_DISP;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               snap <= grid;
               acc  <= '0;
               row  <= '0;
            end
            SCAN: begin
               acc <= acc_nxt;
               row <= row + RW'(1);
               // Load the converter with the total including the final row.
               if (last_row) begin
                  shreg   <= acc_nxt;
                  bcd     <= '0;
                  bit_cnt <= '0;
               end
            end
            CONVERT: begin
               bcd     <= {adj[BCDW-2:0], shreg[CW-1]};
               shreg   <= shreg << 1;
               bit_cnt <= bit_cnt + BW'(1);
            end
            UPDATE: begin
               count        <= acc;
               overflow     <= (64'(acc) >= LIMIT);
               display_data <= (64'(acc) >= LIMIT) ? {DIGITS{8'h40}} : render(bcd);
               done         <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cell_census.sv
// Bench for cell_census: default instance plus a DIGITS=2 instance sharing stimulus,
// checked against a decimal-arithmetic reference model.
module tb_cell_census;
   localparam int W = 20;
   localparam int H = 15;
   typedef logic [H-1:0][W-1:0] grid_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   grid_t       grid = '0;
   logic        busy, done, overflow;
   logic [8:0]  count;
   logic [31:0] disp;
   logic        busy2, done2, ov2;
   logic [8:0]  count2;
   logic [15:0] disp2;

   int checks = 0;
   int errors = 0;
   int prev   = 0;

   always #5 clk = ~clk;

   cell_census #(.WIDTH(W), .HEIGHT(H), .DIGITS(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .grid(grid), .busy(busy), .done(done),
      .count(count), .overflow(overflow), .display_data(disp));

   cell_census #(.WIDTH(W), .HEIGHT(H), .DIGITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .grid(grid), .busy(busy2), .done(done2),
      .count(count2), .overflow(ov2), .display_data(disp2));

   function automatic int model_count(input grid_t g);
      int n = 0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            if (g[r][c]) n++;
      return n;
   endfunction

   function automatic int pow10(input int n);
      int p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   function automatic logic [63:0] model_disp(input int v, input int digits);
      logic [7:0]  tbl [0:9];
      logic [63:0] r;
      int          pw;
      bit          blank;
      tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
      r   = '0;
      if (v >= pow10(digits)) begin
         for (int i = 0; i < digits; i++) r[8*i +: 8] = 8'h40;
      end else begin
         pw = 1;
         for (int i = 0; i < digits; i++) begin
`ifdef CENSUS_BLANK_EN
            blank = (i > 0) && (v < pw);
`else
            blank = 1'b0;
`endif
            r[8*i +: 8] = blank ? 8'h00 : tbl[(v / pw) % 10];
            pw = pw * 10;
         end
      end
      return r;
   endfunction

   function automatic grid_t rand_grid(input bit sparse);
      grid_t g;
      for (int r = 0; r < H; r++) begin
         g[r] = W'($urandom);
         if (sparse) g[r] = g[r] & W'($urandom) & W'($urandom);
      end
      return g;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input int v);
      check({tag, ":count"},  64'(count),  64'(v));
      check({tag, ":ovf"},    64'(overflow), 64'(v >= 10000));
      check({tag, ":disp"},   64'(disp),   model_disp(v, 4));
      check({tag, ":count2"}, 64'(count2), 64'(v));
      check({tag, ":ovf2"},   64'(ov2),    64'(v >= 100));
      check({tag, ":disp2"},  64'(disp2),  model_disp(v, 2));
   endtask

   task automatic census(input grid_t g, input bit toggle, input string tag);
      int n;
      int v;
      v = model_count(g);
      @(negedge clk);
      grid  = g;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      check({tag, ":busy"}, 64'(busy), 64'd1);
      if (toggle) grid = '1;
      while (!done && n < 100) begin
         if (n == 10) check({tag, ":hold"}, 64'(count), 64'(prev));
         @(negedge clk);
         n++;
      end
      check({tag, ":latency"}, 64'(n), 64'd25);
      check({tag, ":busy_lo"}, 64'(busy), 64'd0);
      check({tag, ":done2"}, 64'(done2), 64'd1);
      check_outputs(tag, v);
      prev = v;
      @(negedge clk);
      check({tag, ":pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      grid_t g;
      int    v, k, nd, extra;
      int    t [0:2];

      // Reset state
      repeat (3) @(negedge clk);
      check("rst:busy", 64'(busy), 64'd0);
      check("rst:done", 64'(done), 64'd0);
      check_outputs("rst", 0);
      rst_n = 1'b1;

      census('0, 1'b0, "zero");
      census('1, 1'b0, "ones");
      g = '0;
      g[14][19:13] = '1;
      census(g, 1'b0, "seven");
      g = '0;
      g[0][1] = 1'b1; g[1][2] = 1'b1; g[2][0] = 1'b1; g[2][1] = 1'b1; g[2][2] = 1'b1;
      census(g, 1'b1, "glider");
      for (int i = 0; i < 6; i++) census(rand_grid(i[0]), 1'b0, "rand");

      // start held high: back-to-back censuses, no extra done from start during busy
      g = rand_grid(1'b0);
      v = model_count(g);
      t = '{0, 0, 0};
      nd = 0;
      k = 0;
      @(negedge clk);
      grid  = g;
      start = 1'b1;
      while (nd < 3 && k < 200) begin
         @(negedge clk);
         k++;
         if (done) begin
            t[nd] = k;
            check("held:count", 64'(count), 64'(v));
            nd++;
            if (nd == 3) start = 1'b0;
         end
      end
      check("held:ndone", 64'(nd), 64'd3);
      check("held:first", 64'(t[0]), 64'd26);
      check("held:per1", 64'(t[1] - t[0]), 64'd26);
      check("held:per2", 64'(t[2] - t[1]), 64'd26);
      extra = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) extra++;
      end
      check("held:no_extra", 64'(extra), 64'd0);
      prev = v;

      // Reset in the middle of SCAN
      g = rand_grid(1'b0);
      @(negedge clk);
      grid  = g;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort:busy", 64'(busy), 64'd0);
      check("abort:done", 64'(done), 64'd0);
      check_outputs("abort", 0);
      extra = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) extra++;
      end
      rst_n = 1'b1;
      repeat (30) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      check("abort:quiet", 64'(extra), 64'd0);
      prev = 0;
      census(rand_grid(1'b0), 1'b0, "after_abort");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
